// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit and its datapath muxes.
// State codes, opcodes, mux selects and the packed control word live here.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: maps the current state (plus mem_ready for the
// handshake-qualified strobes) onto the datapath control word.
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] state,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state_t'(state))
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.instr_done    = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-subset main control: state register, next-state logic,
// decoded-opcode latch, illegal-opcode strobe and retired-instruction counter.
module multicycle_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           opcode,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 PCWrite,
   output logic                 PCWriteCond,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 MemtoReg,
   output logic                 IRWrite,
   output logic                 RegWrite,
   output logic                 RegDst,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ALUOp,
   output logic [1:0]           PCSource,
   output logic                 instr_done,
   output logic                 illegal_op,
   output logic [CNT_WIDTH-1:0] instr_count,
   output logic [3:0]           state
);

   state_t     st;
   logic [5:0] op_q;
   logic       ill_q;
   ctrl_t      ctrl;
   ctrl_t      ctrl_g;
   logic       unused_zero;

   // The branch decision is made in the datapath from PCWriteCond and zero.
   assign unused_zero = zero;

   mc_ctrl_outdec u_outdec (
      .state     (st),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st          <= S_FETCH;
         op_q        <= '0;
         ill_q       <= 1'b0;
         instr_count <= '0;
      end else begin
         ill_q <= 1'b0;
         if (ctrl.instr_done)
            instr_count <= instr_count + CNT_WIDTH'(1);
         case (st)
            S_FETCH:  if (mem_ready) st <= S_DECODE;
            S_DECODE: begin
               op_q <= opcode;
               case (opcode)
                  OP_LW, OP_SW: st <= S_MEMADR;
                  OP_R:         st <= S_EXEC;
                  OP_BEQ:       st <= S_BRANCH;
                  OP_J:         st <= S_JUMP;
                  OP_ADDI:      st <= S_ADDIEX;
                  default: begin
                     ill_q <= 1'b1;
                     st    <= S_FETCH;
                  end
               endcase
            end
            S_MEMADR: st <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) st <= S_MEMWB;
            S_MEMWR:  if (mem_ready) st <= S_FETCH;
            S_EXEC:   st <= S_RWB;
            S_ADDIEX: st <= S_ADDIWB;
            default:  st <= S_FETCH;
         endcase
      end
   end

   // Reset masks every strobe immediately, independent of the clock.
   assign ctrl_g      = rst ? '0 : ctrl;
   assign PCWrite     = ctrl_g.pc_write;
   assign PCWriteCond = ctrl_g.pc_write_cond;
   assign IorD        = ctrl_g.iord;
   assign MemRead     = ctrl_g.mem_read;
   assign MemWrite    = ctrl_g.mem_write;
   assign MemtoReg    = ctrl_g.mem_to_reg;
   assign IRWrite     = ctrl_g.ir_write;
   assign RegWrite    = ctrl_g.reg_write;
   assign RegDst      = ctrl_g.reg_dst;
   assign ALUSrcA     = ctrl_g.alu_src_a;
   assign ALUSrcB     = ctrl_g.alu_src_b;
   assign ALUOp       = ctrl_g.alu_op;
   assign PCSource    = ctrl_g.pc_source;
   assign instr_done  = ctrl_g.instr_done;
   assign illegal_op  = ill_q & ~rst;
   assign state       = st;

endmodule
